ir_fetch_unit: RTL and testbench

Instruction-fetch and instruction-register stage of the multicycle CPU. On a start strobe from the control FSM it issues one word read to instruction memory using a req/ack handshake. It then latches the returned word into the instruction register (IR) and holds it for the rest of the instruction's cycles. It exposes the decoded fields of the IR; o_imm16 feeds the sign extension unit directly.

---
 rtl/ir_fetch_unit.sv | 110 +++++++++++
 tb/tb_ir_fetch_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch_unit.sv
// Instruction fetch + IR stage: one word read per start strobe over req/ack,
// result held in IR with decoded field slices.
module ir_fetch_unit #(
  parameter int          ACK_TIMEOUT = 16,
  parameter logic [31:0] IR_RESET    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_fetch_start,
  input  logic [31:0] i_pc,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_req,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy,
  output logic        o_ir_valid,
  output logic        o_fetch_err,
  output logic [31:0] o_instr,
  output logic [5:0]  o_opcode,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [15:0] o_imm16
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic [31:0] r_addr;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic        w_ir_we;
  logic        w_addr_we;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ir    <= IR_RESET;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_ir_we) begin
        r_ir <= i_mem_rdata;
      end
      if (w_addr_we) begin
        r_addr <= i_pc;
      end
    end
  end

  // Ack is checked before the timeout count so a last-cycle ack completes.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_ir_we    = 1'b0;
    w_addr_we  = 1'b0;
    unique case (r_state)
      S_REQ: begin
        if (i_mem_ack) begin
          w_ir_we = 1'b1;
          w_next  = S_DONE;
        end else if (r_cnt == LP_LAST) begin
          w_next = S_ERR;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
        if (i_fetch_start) begin
          w_next     = S_REQ;
          w_addr_we  = 1'b1;
          w_cnt_next = '0;
        end
      end
      default: begin
        if (i_fetch_start) begin
          w_next     = S_REQ;
          w_addr_we  = 1'b1;
          w_cnt_next = '0;
        end
      end
    endcase
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_req   = (r_state == S_REQ);
  assign o_busy      = (r_state == S_REQ);
  assign o_ir_valid  = (r_state == S_DONE);
  assign o_fetch_err = (r_state == S_ERR);

  assign o_instr  = r_ir;
  assign o_opcode = r_ir[31:26];
  assign o_rs     = r_ir[25:21];
  assign o_rt     = r_ir[20:16];
  assign o_rd     = r_ir[15:11];
  assign o_imm16  = r_ir[15:0];

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Directed bench for ir_fetch_unit: zero-wait, wait states, busy start,
// timeout, late ack, reset mid-fetch and back-to-back fetches.
module tb_ir_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        i_fetch_start;
  logic [31:0] i_pc;
  logic [31:0] o_mem_addr;
  logic        o_mem_req;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_busy;
  logic        o_ir_valid;
  logic        o_fetch_err;
  logic [31:0] o_instr;
  logic [5:0]  o_opcode;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
  logic [15:0] o_imm16;

  int tests;
  int fails;
  int vcnt;

  ir_fetch_unit #(
    .ACK_TIMEOUT(16),
    .IR_RESET(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_fetch_start(i_fetch_start),
    .i_pc(i_pc),
    .o_mem_addr(o_mem_addr),
    .o_mem_req(o_mem_req),
    .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy),
    .o_ir_valid(o_ir_valid),
    .o_fetch_err(o_fetch_err),
    .o_instr(o_instr),
    .o_opcode(o_opcode),
    .o_rs(o_rs),
    .o_rt(o_rt),
    .o_rd(o_rd),
    .o_imm16(o_imm16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_ir_valid) vcnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_fetch_start = 1'b0;
    i_pc = '0;
    i_mem_ack = 1'b0;
    i_mem_rdata = '0;
    tick();
    tick();
    tests++;
    if ({o_mem_req, o_busy, o_ir_valid, o_fetch_err} !== 4'b0000) begin
      $display("FAIL reset_flags got=%b exp=0000",
               {o_mem_req, o_busy, o_ir_valid, o_fetch_err});
      fails++;
    end
    tests++;
    if (o_instr !== 32'h0 || o_mem_addr !== 32'h0) begin
      $display("FAIL reset_regs ir=%h addr=%h exp=0/0", o_instr, o_mem_addr);
      fails++;
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait();
    int v0;
    v0 = vcnt;
    i_fetch_start = 1'b1;
    i_pc = 32'h0000_0040;
    tick();
    i_fetch_start = 1'b0;
    tests++;
    if (o_mem_req !== 1'b1 || o_busy !== 1'b1 || o_mem_addr !== 32'h40) begin
      $display("FAIL zw_req req=%b busy=%b addr=%h exp=1/1/40",
               o_mem_req, o_busy, o_mem_addr);
      fails++;
    end
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h2008_FFFC;
    tick();
    i_mem_ack = 1'b0;
    tests++;
    if (o_ir_valid !== 1'b1 || o_mem_req !== 1'b0 || o_busy !== 1'b0) begin
      $display("FAIL zw_valid valid=%b req=%b busy=%b exp=1/0/0",
               o_ir_valid, o_mem_req, o_busy);
      fails++;
    end
    tests++;
    if (o_opcode !== 6'h08 || o_rs !== 5'd0 || o_rt !== 5'd8 ||
        o_imm16 !== 16'hFFFC || o_rd !== 5'd31) begin
      $display("FAIL zw_fields op=%h rs=%0d rt=%0d rd=%0d imm=%h exp=08/0/8/31/fffc",
               o_opcode, o_rs, o_rt, o_rd, o_imm16);
      fails++;
    end
    tick();
    tests++;
    if (o_ir_valid !== 1'b0 || vcnt - v0 != 1 || o_mem_addr !== 32'h40) begin
      $display("FAIL zw_after valid=%b pulses=%0d addr=%h exp=0/1/40",
               o_ir_valid, vcnt - v0, o_mem_addr);
      fails++;
    end
  endtask

  task automatic test_wait_states();
    int v0;
    int nreq;
    int nbusy;
    v0 = vcnt;
    nreq = 0;
    nbusy = 0;
    i_fetch_start = 1'b1;
    i_pc = 32'h0000_0100;
    tick();
    i_fetch_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (o_mem_req) nreq++;
      if (o_busy) nbusy++;
      if (i == 5) begin
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'h8C43_0010;
      end
      tick();
    end
    i_mem_ack = 1'b0;
    if (o_mem_req) nreq++;
    if (o_busy) nbusy++;
    tests++;
    if (nreq != 6 || nbusy != 6) begin
      $display("FAIL ws_req_cycles req=%0d busy=%0d exp=6/6", nreq, nbusy);
      fails++;
    end
    tests++;
    if (o_instr !== 32'h8C43_0010 || o_imm16 !== 16'h0010 || o_ir_valid !== 1'b1) begin
      $display("FAIL ws_ir ir=%h imm=%h valid=%b exp=8c430010/0010/1",
               o_instr, o_imm16, o_ir_valid);
      fails++;
    end
    tick();
    tick();
    tests++;
    if (vcnt - v0 != 1) begin
      $display("FAIL ws_pulses got=%0d exp=1", vcnt - v0);
      fails++;
    end
  endtask

  task automatic test_start_busy();
    int v0;
    v0 = vcnt;
    i_fetch_start = 1'b1;
    i_pc = 32'h0000_0200;
    tick();
    i_pc = 32'h0000_0080;
    tick();
    i_fetch_start = 1'b0;
    tick();
    tests++;
    if (o_mem_addr !== 32'h200 || o_mem_req !== 1'b1) begin
      $display("FAIL busy_addr addr=%h req=%b exp=200/1", o_mem_addr, o_mem_req);
      fails++;
    end
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h0123_4567;
    tick();
    i_mem_ack = 1'b0;
    tick();
    tick();
    tests++;
    if (vcnt - v0 != 1 || o_instr !== 32'h0123_4567 || o_mem_addr !== 32'h200) begin
      $display("FAIL busy_done pulses=%0d ir=%h addr=%h exp=1/01234567/200",
               vcnt - v0, o_instr, o_mem_addr);
      fails++;
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    i_fetch_start = 1'b1;
    i_pc = 32'h0000_0300;
    tick();
    i_fetch_start = 1'b0;
    while (o_mem_req && n < 40) begin
      n++;
      tick();
    end
    tests++;
    if (n != 16) begin
      $display("FAIL to_req_cycles got=%0d exp=16", n);
      fails++;
    end
    tests++;
    if (o_fetch_err !== 1'b1 || o_busy !== 1'b0 || o_instr !== 32'h0123_4567) begin
      $display("FAIL to_err err=%b busy=%b ir=%h exp=1/0/01234567",
               o_fetch_err, o_busy, o_instr);
      fails++;
    end
    tick();
    tick();
    tests++;
    if (o_fetch_err !== 1'b1) begin
      $display("FAIL to_sticky err=%b exp=1", o_fetch_err);
      fails++;
    end
    i_fetch_start = 1'b1;
    i_pc = 32'h0000_0304;
    tick();
    i_fetch_start = 1'b0;
    tests++;
    if (o_fetch_err !== 1'b0 || o_mem_req !== 1'b1 || o_mem_addr !== 32'h304) begin
      $display("FAIL to_clear err=%b req=%b addr=%h exp=0/1/304",
               o_fetch_err, o_mem_req, o_mem_addr);
      fails++;
    end
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'hAABB_CCDD;
    tick();
    i_mem_ack = 1'b0;
    tests++;
    if (o_ir_valid !== 1'b1 || o_instr !== 32'hAABB_CCDD) begin
      $display("FAIL to_recover valid=%b ir=%h exp=1/aabbccdd", o_ir_valid, o_instr);
      fails++;
    end
    tick();
  endtask

  task automatic test_late_ack();
    i_fetch_start = 1'b1;
    i_pc = 32'h0000_0400;
    tick();
    i_fetch_start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    tests++;
    if (o_mem_req !== 1'b1) begin
      $display("FAIL late_still_req req=%b exp=1", o_mem_req);
      fails++;
    end
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h1111_2222;
    tick();
    i_mem_ack = 1'b0;
    tests++;
    if (o_ir_valid !== 1'b1 || o_fetch_err !== 1'b0 || o_instr !== 32'h1111_2222) begin
      $display("FAIL late_ack valid=%b err=%b ir=%h exp=1/0/11112222",
               o_ir_valid, o_fetch_err, o_instr);
      fails++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int v0;
    v0 = vcnt;
    i_fetch_start = 1'b1;
    i_pc = 32'h0000_0500;
    tick();
    i_fetch_start = 1'b0;
    reset_n = 1'b0;
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'hDEAD_BEEF;
    tick();
    reset_n = 1'b1;
    tests++;
    if (o_instr !== 32'h0 || o_mem_req !== 1'b0 || o_ir_valid !== 1'b0 ||
        o_mem_addr !== 32'h0) begin
      $display("FAIL rst_mid ir=%h req=%b valid=%b addr=%h exp=0/0/0/0",
               o_instr, o_mem_req, o_ir_valid, o_mem_addr);
      fails++;
    end
    tick();
    i_mem_ack = 1'b0;
    tick();
    tests++;
    if (o_instr !== 32'h0 || vcnt != v0) begin
      $display("FAIL rst_spurious ir=%h pulses=%0d exp=0/0", o_instr, vcnt - v0);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    i_fetch_start = 1'b1;
    i_pc = 32'h0000_0600;
    tick();
    i_fetch_start = 1'b0;
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h3C01_1234;
    tick();
    i_mem_ack = 1'b0;
    tests++;
    if (o_ir_valid !== 1'b1 || o_instr !== 32'h3C01_1234) begin
      $display("FAIL b2b_first valid=%b ir=%h exp=1/3c011234", o_ir_valid, o_instr);
      fails++;
    end
    i_fetch_start = 1'b1;
    i_pc = 32'h0000_0044;
    tick();
    i_fetch_start = 1'b0;
    tests++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h44 || o_ir_valid !== 1'b0) begin
      $display("FAIL b2b_req req=%b addr=%h valid=%b exp=1/44/0",
               o_mem_req, o_mem_addr, o_ir_valid);
      fails++;
    end
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h0022_1820;
    tick();
    i_mem_ack = 1'b0;
    tests++;
    if (o_ir_valid !== 1'b1 || o_instr !== 32'h0022_1820 || o_rd !== 5'd3) begin
      $display("FAIL b2b_second valid=%b ir=%h rd=%0d exp=1/00221820/3",
               o_ir_valid, o_instr, o_rd);
      fails++;
    end
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    vcnt = 0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_start_busy();
    test_timeout();
    test_late_ack();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
